spi_slave_shifter: RTL

SPI responder (slave) datapath for the peripheral side of the SPI master link. It oversamples the external SCLK, SS_n and MOSI pins in the PCLK domain and supports all four CPOL/CPHA modes with MSB- or LSB-first ordering. It shifts 8-bit frames out on MISO from a one-entry transmit holding register and delivers received bytes to the host logic through a valid/ack handshake.

---
 rtl/spi_slave_shifter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_shifter.sv
// SPI responder datapath: oversampled pins, all four CPOL/CPHA modes, 8-bit frames,
// one-entry transmit holding register and a valid/ack receive handshake.
module spi_slave_shifter (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       lsbfe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       miso,
    output logic       miso_oe,
    output logic       busy,
    output logic       overrun,
    output logic       underrun
);

    // bit 0 = s1, bit 1 = s2, bit 2 = s3
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] ss_sync_q, ss_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    logic       cpol_q, cpol_d, cpha_q, cpha_d, lsbfe_q, lsbfe_d;
    logic       busy_q, busy_d, miso_oe_q, miso_oe_d, miso_q, miso_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rsr_q, rsr_d, tsr_q, tsr_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d, underrun_q, underrun_d;

    logic       frame_start, frame_end, lead_ev, trail_ev, sample_ev, shift_ev;
    logic       ord_lsb, do_load, deliver;
    logic [7:0] rx_byte, load_byte;

    assign frame_start = ss_sync_q[2] & ~ss_sync_q[1];
    assign frame_end   = ~ss_sync_q[2] & ss_sync_q[1];
    assign lead_ev     = (sclk_sync_q[1] != cpol_q) && (sclk_sync_q[2] == cpol_q);
    assign trail_ev    = (sclk_sync_q[1] == cpol_q) && (sclk_sync_q[2] != cpol_q);
    assign sample_ev   = busy_q && (cpha_q ? trail_ev : lead_ev);
    assign shift_ev    = busy_q && (cpha_q ? lead_ev : trail_ev);

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        ss_sync_d   = {ss_sync_q[1:0], ss_n};
        mosi_sync_d = {mosi_sync_q[0], mosi};
    end

    always_comb begin
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        lsbfe_d     = lsbfe_q;
        busy_d      = busy_q;
        miso_oe_d   = miso_oe_q;
        miso_d      = miso_q;
        cnt_d       = cnt_q;
        rsr_d       = rsr_q;
        tsr_d       = tsr_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        underrun_d  = 1'b0;
        do_load     = 1'b0;
        deliver     = 1'b0;
        // At frame start the mode pins are used directly since the latches update this cycle
        ord_lsb     = frame_start ? lsbfe : lsbfe_q;
        rx_byte     = lsbfe_q ? {mosi_sync_q[1], rsr_q[7:1]} : {rsr_q[6:0], mosi_sync_q[1]};
        load_byte   = hold_full_q ? hold_q : 8'hFF;

        if (frame_start) begin
            cpol_d    = cpol;
            cpha_d    = cpha;
            lsbfe_d   = lsbfe;
            cnt_d     = 3'd0;
            miso_oe_d = 1'b1;
            busy_d    = 1'b1;
            do_load   = ~cpha;
        end else if (frame_end) begin
            miso_oe_d = 1'b0;
            busy_d    = 1'b0;
            cnt_d     = 3'd0;
            miso_d    = 1'b0;
        end else begin
            // A shift edge with the counter at zero starts a new byte rather than shifting
            if (shift_ev) begin
                if (cnt_q == 3'd0) begin
                    do_load = 1'b1;
                end else begin
                    tsr_d  = ord_lsb ? {1'b0, tsr_q[7:1]} : {tsr_q[6:0], 1'b0};
                    miso_d = ord_lsb ? tsr_q[1] : tsr_q[6];
                end
            end
            if (sample_ev) begin
                rsr_d   = rx_byte;
                cnt_d   = cnt_q + 3'd1;
                deliver = (cnt_q == 3'd7);
            end
        end

        if (do_load) begin
            tsr_d       = load_byte;
            miso_d      = ord_lsb ? load_byte[0] : load_byte[7];
            underrun_d  = ~hold_full_q;
            hold_full_d = 1'b0;
        end

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
        if (deliver) begin
            if (rx_valid_q && !rx_ack) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sclk_sync_q <= 3'b000;
            ss_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsbfe_q     <= 1'b0;
            busy_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            miso_q      <= 1'b0;
            cnt_q       <= 3'd0;
            rsr_q       <= 8'h00;
            tsr_q       <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            lsbfe_q     <= lsbfe_d;
            busy_q      <= busy_d;
            miso_oe_q   <= miso_oe_d;
            miso_q      <= miso_d;
            cnt_q       <= cnt_d;
            rsr_q       <= rsr_d;
            tsr_q       <= tsr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
        end
    end

    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule
